// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU codes, T-states and
// the per-instruction-class decode helpers.
package cpu_pkg;

  typedef enum logic [4:0] {
    OpLd   = 5'd0,
    OpLdi  = 5'd1,
    OpSt   = 5'd2,
    OpAdd  = 5'd3,
    OpSub  = 5'd4,
    OpAnd  = 5'd5,
    OpOr   = 5'd6,
    OpShr  = 5'd7,
    OpShl  = 5'd8,
    OpRor  = 5'd9,
    OpRol  = 5'd10,
    OpAddi = 5'd11,
    OpAndi = 5'd12,
    OpOri  = 5'd13,
    OpMul  = 5'd14,
    OpDiv  = 5'd15,
    OpNeg  = 5'd16,
    OpNot  = 5'd17,
    OpBr   = 5'd18,
    OpJr   = 5'd19,
    OpJal  = 5'd20,
    OpIn   = 5'd21,
    OpOut  = 5'd22,
    OpMfhi = 5'd23,
    OpMflo = 5'd24,
    OpNop  = 5'd25,
    OpHalt = 5'd26
  } opcode_e;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluShr = 4'd4,
    AluShl = 4'd5,
    AluRor = 4'd6,
    AluRol = 4'd7,
    AluMul = 4'd8,
    AluDiv = 4'd9,
    AluNeg = 4'd10,
    AluNot = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAluReg, ClsAluImm, ClsLdi, ClsLd, ClsSt, ClsBr, ClsMulDiv, ClsNegNot,
    ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } op_class_e;

  typedef struct packed {
    logic    pc_out;
    logic    zlow_out;
    logic    zhigh_out;
    logic    mdr_out;
    logic    hi_out;
    logic    lo_out;
    logic    inport_out;
    logic    c_out;
    logic    ba_out;
    logic    r_out;
    logic    mar_in;
    logic    z_in;
    logic    pc_in;
    logic    mdr_in;
    logic    ir_in;
    logic    y_in;
    logic    hi_in;
    logic    lo_in;
    logic    outport_in;
    logic    r_in;
    logic    con_in;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    inc_pc;
    logic    read;
    logic    write;
    alu_op_e control;
  } ctrl_t;

  // Undefined opcodes fall into the nop class.
  function automatic op_class_e op_class(input opcode_e op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol: return ClsAluReg;
      OpAddi, OpAndi, OpOri:                                 return ClsAluImm;
      OpLdi:                                                 return ClsLdi;
      OpLd:                                                  return ClsLd;
      OpSt:                                                  return ClsSt;
      OpBr:                                                  return ClsBr;
      OpMul, OpDiv:                                          return ClsMulDiv;
      OpNeg, OpNot:                                          return ClsNegNot;
      OpJr:                                                  return ClsJr;
      OpJal:                                                 return ClsJal;
      OpIn:                                                  return ClsIn;
      OpOut:                                                 return ClsOut;
      OpMfhi:                                                return ClsMfhi;
      OpMflo:                                                return ClsMflo;
      OpHalt:                                                return ClsHalt;
      default:                                               return ClsNop;
    endcase
  endfunction

  // Final execute step of each class; the step after it is T0.
  function automatic state_e last_step(input op_class_e cls);
    case (cls)
      ClsAluReg, ClsAluImm, ClsLdi: return StT5;
      ClsLd, ClsSt:                 return StT7;
      ClsBr, ClsMulDiv:             return StT6;
      ClsNegNot, ClsJal:            return StT4;
      default:                      return StT3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit to datapath bundle: IR/condition/memory-ready in, every strobe out.
interface control_sequencer_if;

  logic [31:0] ir;
  logic        con_ff;
  logic        mem_ready;

  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin;
  logic GRA, GRB, GRC;
  logic IncPc;
  logic read, write;
  logic [3:0] control;
  logic run;

  modport master (
    input  ir, con_ff, mem_ready,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin,
    output GRA, GRB, GRC, IncPc, read, write, control, run
  );

  modport slave (
    output ir, con_ff, mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin,
    input  GRA, GRB, GRC, IncPc, read, write, control, run
  );

endinterface

// File: rtl/op_to_alu.sv
// Opcode to ALU function code; anything without a dedicated function adds.
module op_to_alu
  import cpu_pkg::*;
(
  input  opcode_e opcode_i,
  output alu_op_e alu_op_o
);

  always_comb begin
    alu_op_o = AluAdd;
    case (opcode_i)
      OpSub:        alu_op_o = AluSub;
      OpAnd, OpAndi: alu_op_o = AluAnd;
      OpOr, OpOri:  alu_op_o = AluOr;
      OpShr:        alu_op_o = AluShr;
      OpShl:        alu_op_o = AluShl;
      OpRor:        alu_op_o = AluRor;
      OpRol:        alu_op_o = AluRol;
      OpMul:        alu_op_o = AluMul;
      OpDiv:        alu_op_o = AluDiv;
      OpNeg:        alu_op_o = AluNeg;
      OpNot:        alu_op_o = AluNot;
      default:      alu_op_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer for the single-bus datapath: fetch, decode IR[31:27],
// step the per-class execute sequence, stall on memory-ready, park on halt.
module control_sequencer
  import cpu_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master seq_io
);

  state_e    state_q, state_d;
  opcode_e   opcode;
  op_class_e cls;
  state_e    last;
  alu_op_e   alu_op;
  ctrl_t     ctrl;
  logic      run;
  logic      unused_ir;

  assign opcode    = opcode_e'(seq_io.ir[31:27]);
  assign unused_ir = ^seq_io.ir[26:0];
  assign cls       = op_class(opcode);
  assign last      = last_step(cls);

  op_to_alu u_op_to_alu (
    .opcode_i(opcode),
    .alu_op_o(alu_op)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:  state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (seq_io.mem_ready) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (cls == ClsHalt)     state_d = StHalt;
        else if (last == StT3)  state_d = StT0;
        else                    state_d = StT4;
      end
      StT4:   state_d = (last == StT4) ? StT0 : StT5;
      StT5:   state_d = (last == StT5) ? StT0 : StT6;
      StT6: begin
        if (cls == ClsLd)       state_d = seq_io.mem_ready ? StT7 : StT6;
        else if (last == StT6)  state_d = StT0;
        else                    state_d = StT7;
      end
      StT7:   if (cls != ClsSt || seq_io.mem_ready) state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // Gated by reset so every output drops in the same cycle reset asserts.
  always_comb begin
    ctrl = '0;
    run  = 1'b0;
    if (reset) begin
      run = (state_q != StHalt) && !(state_q == StT3 && cls == ClsHalt);
      unique case (state_q)
        StT0: begin
          ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
        end
        StT1: begin
          ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end
        StT2: begin
          ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
        end
        StT3: begin
          unique case (cls)
            ClsAluReg, ClsAluImm: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ClsLdi, ClsLd, ClsSt: begin
              ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ClsBr: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
            end
            ClsMulDiv: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ClsNegNot: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = alu_op;
            end
            ClsJr: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
            end
            ClsJal: begin
              ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsIn: begin
              ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsOut: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1;
            end
            ClsMfhi: begin
              ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsMflo: begin
              ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          unique case (cls)
            ClsAluReg: begin
              ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = alu_op;
            end
            ClsAluImm: begin
              ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = alu_op;
            end
            ClsLdi, ClsLd, ClsSt: begin
              ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = AluAdd;
            end
            ClsBr: begin
              ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ClsMulDiv: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = alu_op;
            end
            ClsNegNot: begin
              ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsJal: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          unique case (cls)
            ClsAluReg, ClsAluImm, ClsLdi: begin
              ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsLd, ClsSt: begin
              ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
            end
            ClsBr: begin
              ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.control = AluAdd;
            end
            ClsMulDiv: begin
              ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
            end
            default: ;
          endcase
        end
        StT6: begin
          unique case (cls)
            ClsLd: begin
              ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            // read stays low so the MDR input mux takes the bus, not memory.
            ClsSt: begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ClsBr: begin
              ctrl.zlow_out = seq_io.con_ff; ctrl.pc_in = seq_io.con_ff;
            end
            ClsMulDiv: begin
              ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
            end
            default: ;
          endcase
        end
        StT7: begin
          unique case (cls)
            ClsLd: begin
              ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            ClsSt:   ctrl.write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign seq_io.PCout     = ctrl.pc_out;
  assign seq_io.Zlowout   = ctrl.zlow_out;
  assign seq_io.Zhighout  = ctrl.zhigh_out;
  assign seq_io.MDRout    = ctrl.mdr_out;
  assign seq_io.HIout     = ctrl.hi_out;
  assign seq_io.LOout     = ctrl.lo_out;
  assign seq_io.InPortout = ctrl.inport_out;
  assign seq_io.Cout      = ctrl.c_out;
  assign seq_io.BAout     = ctrl.ba_out;
  assign seq_io.Rout      = ctrl.r_out;
  assign seq_io.MARin     = ctrl.mar_in;
  assign seq_io.Zin       = ctrl.z_in;
  assign seq_io.PCin      = ctrl.pc_in;
  assign seq_io.MDRin     = ctrl.mdr_in;
  assign seq_io.IRin      = ctrl.ir_in;
  assign seq_io.Yin       = ctrl.y_in;
  assign seq_io.HIin      = ctrl.hi_in;
  assign seq_io.LOin      = ctrl.lo_in;
  assign seq_io.OutPortin = ctrl.outport_in;
  assign seq_io.Rin       = ctrl.r_in;
  assign seq_io.CONin     = ctrl.con_in;
  assign seq_io.GRA       = ctrl.gra;
  assign seq_io.GRB       = ctrl.grb;
  assign seq_io.GRC       = ctrl.grc;
  assign seq_io.IncPc     = ctrl.inc_pc;
  assign seq_io.read      = ctrl.read;
  assign seq_io.write     = ctrl.write;
  assign seq_io.control   = ctrl.control;
  assign seq_io.run       = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected strobe vectors are queued from the
// instruction tables and compared, one per clock, as the sequencer steps.
module tb_control_sequencer;

  logic clk;
  logic reset;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .seq_io(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] BPcOut     = 32'd1 << 0;
  localparam logic [31:0] BZlowOut   = 32'd1 << 1;
  localparam logic [31:0] BZhighOut  = 32'd1 << 2;
  localparam logic [31:0] BMdrOut    = 32'd1 << 3;
  localparam logic [31:0] BHiOut     = 32'd1 << 4;
  localparam logic [31:0] BLoOut     = 32'd1 << 5;
  localparam logic [31:0] BInPortOut = 32'd1 << 6;
  localparam logic [31:0] BCOut      = 32'd1 << 7;
  localparam logic [31:0] BBaOut     = 32'd1 << 8;
  localparam logic [31:0] BROut      = 32'd1 << 9;
  localparam logic [31:0] BMarIn     = 32'd1 << 10;
  localparam logic [31:0] BZIn       = 32'd1 << 11;
  localparam logic [31:0] BPcIn      = 32'd1 << 12;
  localparam logic [31:0] BMdrIn     = 32'd1 << 13;
  localparam logic [31:0] BIrIn      = 32'd1 << 14;
  localparam logic [31:0] BYIn       = 32'd1 << 15;
  localparam logic [31:0] BHiIn      = 32'd1 << 16;
  localparam logic [31:0] BLoIn      = 32'd1 << 17;
  localparam logic [31:0] BOutPortIn = 32'd1 << 18;
  localparam logic [31:0] BRIn       = 32'd1 << 19;
  localparam logic [31:0] BConIn     = 32'd1 << 20;
  localparam logic [31:0] BGra       = 32'd1 << 21;
  localparam logic [31:0] BGrb       = 32'd1 << 22;
  localparam logic [31:0] BGrc       = 32'd1 << 23;
  localparam logic [31:0] BIncPc     = 32'd1 << 24;
  localparam logic [31:0] BRead      = 32'd1 << 25;
  localparam logic [31:0] BWrite     = 32'd1 << 26;
  localparam logic [31:0] BRun       = 32'd1 << 31;

  logic [31:0] obs;
  assign obs = {bus_if.run, bus_if.control, bus_if.write, bus_if.read, bus_if.IncPc,
                bus_if.GRC, bus_if.GRB, bus_if.GRA, bus_if.CONin, bus_if.Rin,
                bus_if.OutPortin, bus_if.LOin, bus_if.HIin, bus_if.Yin, bus_if.IRin,
                bus_if.MDRin, bus_if.PCin, bus_if.Zin, bus_if.MARin, bus_if.Rout,
                bus_if.BAout, bus_if.Cout, bus_if.InPortout, bus_if.LOout, bus_if.HIout,
                bus_if.MDRout, bus_if.Zhighout, bus_if.Zlowout, bus_if.PCout};

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        mr;
    logic        cf;
    logic [31:0] vec;
  } step_t;

  step_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] ctl(input logic [3:0] c);
    return {1'b0, c, 27'd0};
  endfunction

  task automatic push(input string name, input logic [4:0] op, input logic mr, input logic cf,
                      input logic [31:0] vec);
    step_t s;
    s.name = $sformatf("op%0d %s", op, name);
    s.ir   = {op, 27'h0123456};
    s.mr   = mr;
    s.cf   = cf;
    s.vec  = vec;
    sb_q.push_back(s);
  endtask

  task automatic push_fetch(input logic [4:0] op, input int waits, input logic cf);
    push("T0", op, 1'b1, cf, BPcOut | BMarIn | BIncPc | BZIn | BRun);
    for (int i = 0; i < waits; i++)
      push("T1 wait", op, 1'b0, cf, BZlowOut | BPcIn | BRead | BMdrIn | BRun);
    push("T1", op, 1'b1, cf, BZlowOut | BPcIn | BRead | BMdrIn | BRun);
    push("T2", op, 1'b1, cf, BMdrOut | BIrIn | BRun);
  endtask

  // Drive one queued cycle's inputs, sample outputs mid-cycle, advance past the edge.
  task automatic step(output step_t s, output logic [31:0] o);
    s = sb_q.pop_front();
    bus_if.ir        = s.ir;
    bus_if.mem_ready = s.mr;
    bus_if.con_ff    = s.cf;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    checks++;
    if ($countones(obs[9:0]) > 1) begin
      errors++;
      $display("FAIL bus_drive got=%b expected at most one high", obs[9:0]);
    end
  end

  task automatic test_reset();
    step_t s;
    logic [31:0] o;
    reset            = 1'b0;
    bus_if.ir        = '0;
    bus_if.mem_ready = 1'b1;
    bus_if.con_ff    = 1'b0;
    #2;
    checks++;
    if (obs !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=%h", obs, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push("S_RST", 5'd0, 1'b1, 1'b0, BRun);
    push_fetch(5'd0, 0, 1'b0);
    push("T3", 5'd0, 1'b1, 1'b0, BGrb | BBaOut | BYIn | BRun);
    push("T4", 5'd0, 1'b1, 1'b0, BCOut | BZIn | ctl(4'd0) | BRun);
    push("T5", 5'd0, 1'b1, 1'b0, BZlowOut | BMarIn | BRun);
    push("T6", 5'd0, 1'b0, 1'b0, BRead | BMdrIn | BRun);
    push("T6 wait", 5'd0, 1'b0, 1'b0, BRead | BMdrIn | BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
    // Still stalled in ld T6; reset lands mid-access.
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_T6 got=%h expected=%h", obs, 32'd0);
    end
    @(negedge clk);
    checks++;
    if (obs !== 32'd0) begin
      errors++;
      $display("FAIL reset_held got=%h expected=%h", obs, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push("S_RST", 5'd25, 1'b1, 1'b0, BRun);
    push_fetch(5'd25, 0, 1'b0);
    push("T3", 5'd25, 1'b1, 1'b0, BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_alu();
    step_t s;
    logic [31:0] o;
    logic [4:0] ops [6] = '{5'd3, 5'd3, 5'd4, 5'd10, 5'd13, 5'd1};
    logic [3:0] alu [6] = '{4'd0, 4'd0, 4'd1, 4'd7, 4'd3, 4'd0};
    for (int i = 0; i < 6; i++) begin
      push_fetch(ops[i], 0, 1'b0);
      if (ops[i] == 5'd1) begin
        push("T3", ops[i], 1'b1, 1'b0, BGrb | BBaOut | BYIn | BRun);
        push("T4", ops[i], 1'b1, 1'b0, BCOut | BZIn | ctl(alu[i]) | BRun);
      end else if (ops[i] >= 5'd11) begin
        push("T3", ops[i], 1'b1, 1'b0, BGrb | BROut | BYIn | BRun);
        push("T4", ops[i], 1'b1, 1'b0, BCOut | BZIn | ctl(alu[i]) | BRun);
      end else begin
        push("T3", ops[i], 1'b1, 1'b0, BGrb | BROut | BYIn | BRun);
        push("T4", ops[i], 1'b1, 1'b0, BGrc | BROut | BZIn | ctl(alu[i]) | BRun);
      end
      push("T5", ops[i], 1'b1, 1'b0, BZlowOut | BGra | BRIn | BRun);
    end
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_fetch_wait();
    step_t s;
    logic [31:0] o;
    push_fetch(5'd21, 3, 1'b0);
    push("T3", 5'd21, 1'b1, 1'b0, BInPortOut | BGra | BRIn | BRun);
    push_fetch(5'd22, 1, 1'b0);
    push("T3", 5'd22, 1'b1, 1'b0, BGra | BROut | BOutPortIn | BRun);
    push_fetch(5'd23, 0, 1'b0);
    push("T3", 5'd23, 1'b1, 1'b0, BHiOut | BGra | BRIn | BRun);
    push_fetch(5'd24, 0, 1'b0);
    push("T3", 5'd24, 1'b1, 1'b0, BLoOut | BGra | BRIn | BRun);
    push_fetch(5'd19, 0, 1'b0);
    push("T3", 5'd19, 1'b1, 1'b0, BGra | BROut | BPcIn | BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_branch();
    step_t s;
    logic [31:0] o;
    for (int c = 0; c < 2; c++) begin
      push_fetch(5'd18, 0, c[0]);
      push("T3", 5'd18, 1'b1, c[0], BGra | BROut | BConIn | BRun);
      push("T4", 5'd18, 1'b1, c[0], BPcOut | BYIn | BRun);
      push("T5", 5'd18, 1'b1, c[0], BCOut | BZIn | ctl(4'd0) | BRun);
      push(c[0] ? "T6 taken" : "T6 not taken", 5'd18, 1'b1, c[0],
           c[0] ? (BZlowOut | BPcIn | BRun) : BRun);
    end
    push_fetch(5'd25, 0, 1'b0);
    push("T3", 5'd25, 1'b1, 1'b0, BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_store();
    step_t s;
    logic [31:0] o;
    push_fetch(5'd2, 0, 1'b0);
    push("T3", 5'd2, 1'b1, 1'b0, BGrb | BBaOut | BYIn | BRun);
    push("T4", 5'd2, 1'b1, 1'b0, BCOut | BZIn | ctl(4'd0) | BRun);
    push("T5", 5'd2, 1'b1, 1'b0, BZlowOut | BMarIn | BRun);
    push("T6", 5'd2, 1'b0, 1'b0, BGra | BROut | BMdrIn | BRun);
    push("T7 wait", 5'd2, 1'b0, 1'b0, BWrite | BRun);
    push("T7 wait", 5'd2, 1'b0, 1'b0, BWrite | BRun);
    push("T7", 5'd2, 1'b1, 1'b0, BWrite | BRun);
    push_fetch(5'd0, 0, 1'b0);
    push("T3", 5'd0, 1'b1, 1'b0, BGrb | BBaOut | BYIn | BRun);
    push("T4", 5'd0, 1'b1, 1'b0, BCOut | BZIn | BRun);
    push("T5", 5'd0, 1'b1, 1'b0, BZlowOut | BMarIn | BRun);
    push("T6 wait", 5'd0, 1'b0, 1'b0, BRead | BMdrIn | BRun);
    push("T6", 5'd0, 1'b1, 1'b0, BRead | BMdrIn | BRun);
    push("T7", 5'd0, 1'b0, 1'b0, BMdrOut | BGra | BRIn | BRun);
    push_fetch(5'd25, 0, 1'b0);
    push("T3", 5'd25, 1'b1, 1'b0, BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_muldiv_misc();
    step_t s;
    logic [31:0] o;
    logic [4:0] ops [2] = '{5'd14, 5'd15};
    logic [3:0] alu [2] = '{4'd8, 4'd9};
    for (int i = 0; i < 2; i++) begin
      push_fetch(ops[i], 0, 1'b0);
      push("T3", ops[i], 1'b1, 1'b0, BGra | BROut | BYIn | BRun);
      push("T4", ops[i], 1'b1, 1'b0, BGrb | BROut | BZIn | ctl(alu[i]) | BRun);
      push("T5", ops[i], 1'b1, 1'b0, BZlowOut | BLoIn | BRun);
      push("T6", ops[i], 1'b1, 1'b0, BZhighOut | BHiIn | BRun);
    end
    push_fetch(5'd16, 0, 1'b0);
    push("T3", 5'd16, 1'b1, 1'b0, BGrb | BROut | BZIn | ctl(4'd10) | BRun);
    push("T4", 5'd16, 1'b1, 1'b0, BZlowOut | BGra | BRIn | BRun);
    push_fetch(5'd17, 0, 1'b0);
    push("T3", 5'd17, 1'b1, 1'b0, BGrb | BROut | BZIn | ctl(4'd11) | BRun);
    push("T4", 5'd17, 1'b1, 1'b0, BZlowOut | BGra | BRIn | BRun);
    push_fetch(5'd20, 0, 1'b0);
    push("T3", 5'd20, 1'b1, 1'b0, BPcOut | BGrb | BRIn | BRun);
    push("T4", 5'd20, 1'b1, 1'b0, BGra | BROut | BPcIn | BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_undefined();
    step_t s;
    logic [31:0] o;
    push_fetch(5'd31, 0, 1'b0);
    push("T3", 5'd31, 1'b1, 1'b0, BRun);
    push_fetch(5'd27, 0, 1'b0);
    push("T3", 5'd27, 1'b1, 1'b0, BRun);
    push_fetch(5'd25, 0, 1'b0);
    push("T3", 5'd25, 1'b1, 1'b0, BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  task automatic test_halt();
    step_t s;
    logic [31:0] o;
    push_fetch(5'd26, 0, 1'b0);
    for (int i = 0; i < 20; i++) push("halted", 5'd26, 1'b1, 1'b0, 32'd0);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    push("S_RST", 5'd25, 1'b1, 1'b0, BRun);
    push_fetch(5'd25, 0, 1'b0);
    push("T3", 5'd25, 1'b1, 1'b0, BRun);
    while (sb_q.size() != 0) begin
      step(s, o);
      checks++;
      if (o !== s.vec) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", s.name, o, s.vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fetch_wait();
    test_branch();
    test_store();
    test_muldiv_misc();
    test_undefined();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
